edge_counter_bank: RTL and testbench

EDGE_COUNTER_BANK -- requirements
Module: edge_counter_bank

---
 rtl/edge_counter_pkg.sv | 22 ++
 rtl/edge_counter_bank_if.sv | 16 +
 rtl/edge_counter_chan.sv | 69 ++++++
 rtl/edge_counter_bank.sv | 90 +++++++++
 tb/tb_edge_counter_bank.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_counter_pkg.sv
// Shared read-FSM state type, parameter-range limits and select-width helper
// for the edge counter bank.
package edge_counter_pkg;

    localparam int NCH_MIN  = 1;
    localparam int NCH_MAX  = 16;
    localparam int CW_MIN   = 2;
    localparam int CW_MAX   = 16;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rd_state_e;

    // A single channel still needs a one-bit select port.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/edge_counter_bank_if.sv
// Four-phase read port of the edge counter bank: channel select, request,
// acknowledge and captured count.
interface edge_counter_bank_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
) ();
    localparam int SW = edge_counter_pkg::sel_width(NCH);

    logic [SW-1:0] rd_sel;
    logic          rd_req;
    logic          rd_ack;
    logic [CW-1:0] rd_data;

    modport master (output rd_sel, output rd_req, input rd_ack, input rd_data);
    modport slave  (input rd_sel, input rd_req, output rd_ack, output rd_data);
endinterface

// File: rtl/edge_counter_chan.sv
// One channel: input synchroniser, rising-edge detect, toggle, event counter
// and sticky overflow. EDGE_CNT_SAT_EN selects saturating instead of wrapping count.
module edge_counter_chan #(
    parameter int CW   = 8,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_i,
    input  logic          clr_i,
    output logic          x_o,
    output logic          y_o,
    output logic [CW-1:0] cnt_o,
    output logic          ovf_o
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [SYNC-1:0] sync_q;
    logic            prev_q;
    logic            x_q, y_q, ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rise;

    always_comb begin
        rise  = sync_q[SYNC-1] & ~prev_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // clr takes priority, so an edge in the clearing cycle is not counted
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (rise) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
`ifdef EDGE_CNT_SAT_EN
                cnt_d = CNT_MAX;
`else
                cnt_d = '0;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            x_q    <= 1'b0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], a_i};
            prev_q <= sync_q[SYNC-1];
            x_q    <= rise;
            y_q    <= y_q ^ rise;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/edge_counter_bank.sv
// Bank of NCH edge-counting channels with a four-phase read port that captures
// one channel's count. Counter overflow policy is set by EDGE_CNT_SAT_EN.
//
// state | meaning
// IDLE  | no read in progress, rd_ack low; rd_req captures cnt[rd_sel]
// ACK   | rd_data held, rd_ack high until rd_req drops
module edge_counter_bank import edge_counter_pkg::*; #(
    parameter int NCH  = 4,
    parameter int CW   = 8,
    parameter int SYNC = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCH-1:0]            a,
    input  logic                      clr,
    input  logic [sel_width(NCH)-1:0] rd_sel,
    input  logic                      rd_req,
    output logic                      rd_ack,
    output logic [CW-1:0]             rd_data,
    output logic [NCH-1:0]            x,
    output logic [NCH-1:0]            y,
    output logic [NCH-1:0]            ovf
);
    localparam int SW = sel_width(NCH);

    edge_counter_bank_if #(.NCH(NCH), .CW(CW)) rd_bus ();

    assign rd_bus.rd_sel = rd_sel;
    assign rd_bus.rd_req = rd_req;
    assign rd_ack        = rd_bus.rd_ack;
    assign rd_data       = rd_bus.rd_data;

    logic [CW-1:0] cnt_w [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        edge_counter_chan #(.CW(CW), .SYNC(SYNC)) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .a_i     (a[i]),
            .clr_i   (clr),
            .x_o     (x[i]),
            .y_o     (y[i]),
            .cnt_o   (cnt_w[i]),
            .ovf_o   (ovf[i])
        );
    end

    rd_state_e     state_q, state_d;
    logic [CW-1:0] rd_data_q, rd_data_d;
    logic [CW-1:0] sel_cnt;

    // Selects with no matching channel read back as zero.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_bus.rd_sel == SW'(i)) sel_cnt = cnt_w[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (rd_bus.rd_req) begin
                    state_d   = ACK;
                    rd_data_d = sel_cnt;
                end
            end
            ACK: begin
                if (!rd_bus.rd_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_bus.rd_ack  = (state_q == ACK);
    assign rd_bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_edge_counter_bank.sv
// Directed bench for edge_counter_bank (NCH=4, CW=4, SYNC=2) with a per-cycle
// comparison against an event-count model plus hand-computed checkpoints.
module tb_edge_counter_bank;
    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int SYNC = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] a = '0;
    logic           clr = 1'b0;
    logic [NCH-1:0] x, y, ovf;

    int nvec = 0;
    int nerr = 0;
    bit done = 1'b0;

    edge_counter_bank_if #(.NCH(NCH), .CW(CW)) rd_bus ();

    edge_counter_bank #(.NCH(NCH), .CW(CW), .SYNC(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .clr     (clr),
        .rd_sel  (rd_bus.rd_sel),
        .rd_req  (rd_bus.rd_req),
        .rd_ack  (rd_bus.rd_ack),
        .rd_data (rd_bus.rd_data),
        .x       (x),
        .y       (y),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Model: inputs seen through a SYNC-edge delay line, events counted as plain integers.
    bit             sh [NCH][SYNC+1];
    int             ev [NCH];
    logic [NCH-1:0] x_m = '0;
    logic [NCH-1:0] y_m = '0;
    logic           ack_m = 1'b0;
    logic [CW-1:0]  data_m = '0;

    function automatic logic [CW-1:0] cnt_of(input int n);
`ifdef EDGE_CNT_SAT_EN
        return CW'((n > CMAX) ? CMAX : n);
`else
        return CW'(n % (CMAX + 1));
`endif
    endfunction

    function automatic logic [NCH-1:0] ovf_of();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (ev[i] > CMAX);
        return r;
    endfunction

    initial begin
        for (int i = 0; i < NCH; i++) begin
            ev[i] = 0;
            for (int k = 0; k <= SYNC; k++) sh[i][k] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                x_m = '0; y_m = '0; ack_m = 1'b0; data_m = '0;
                for (int i = 0; i < NCH; i++) begin
                    ev[i] = 0;
                    for (int k = 0; k <= SYNC; k++) sh[i][k] = 1'b0;
                end
            end else begin
                if (!ack_m && rd_bus.rd_req) begin
                    ack_m  = 1'b1;
                    data_m = (int'(rd_bus.rd_sel) < NCH) ? cnt_of(ev[rd_bus.rd_sel]) : '0;
                end else if (ack_m && !rd_bus.rd_req) begin
                    ack_m = 1'b0;
                end
                for (int i = 0; i < NCH; i++) begin
                    x_m[i] = sh[i][SYNC-1] && !sh[i][SYNC];
                    if (x_m[i]) y_m[i] = ~y_m[i];
                    if (clr) ev[i] = 0;
                    else if (x_m[i]) ev[i] = ev[i] + 1;
                    for (int k = SYNC; k > 0; k--) sh[i][k] = sh[i][k-1];
                    sh[i][0] = a[i];
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    initial begin
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                check("x", 16'(x), 16'(x_m));
                check("y", 16'(y), 16'(y_m));
                check("ovf", 16'(ovf), 16'(ovf_of()));
                check("rd_ack", 16'(rd_bus.rd_ack), 16'(ack_m));
                check("rd_data", 16'(rd_bus.rd_data), 16'(data_m));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int ch);
        a[ch] = 1'b1;
        step(2);
        a[ch] = 1'b0;
        step(2);
    endtask

    task automatic read(input int ch, input logic [CW-1:0] exp, input string name);
        rd_bus.rd_sel = 2'(ch);
        rd_bus.rd_req = 1'b1;
        step(1);
        check({name, "_ack"}, 16'(rd_bus.rd_ack), 16'd1);
        check({name, "_data"}, 16'(rd_bus.rd_data), 16'(exp));
        rd_bus.rd_req = 1'b0;
        step(1);
        check({name, "_ack_drop"}, 16'(rd_bus.rd_ack), 16'd0);
    endtask

    initial begin
        rd_bus.rd_sel = '0;
        rd_bus.rd_req = 1'b0;
        step(3);
        reset_n = 1'b1;
        check("rst_x", 16'(x), 16'd0);
        check("rst_y", 16'(y), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);
        check("rst_ack", 16'(rd_bus.rd_ack), 16'd0);
        check("rst_data", 16'(rd_bus.rd_data), 16'd0);

        // single held edge on channel 0
        a[0] = 1'b1;
        step(2);
        check("ch0_x_early", 16'(x), 16'd0);
        step(1);
        check("ch0_x_pulse", 16'(x), 16'b0001);
        check("ch0_y", 16'(y), 16'b0001);
        step(1);
        check("ch0_x_single", 16'(x), 16'd0);
        read(0, 4'd1, "ch0_cnt");
        check("ch0_data_kept", 16'(rd_bus.rd_data), 16'd1);
        a[0] = 1'b0;
        step(2);

        // 17 edges on channel 1 overflow a 4-bit counter
        repeat (17) pulse(1);
        step(2);
        check("ch1_ovf", 16'(ovf), 16'b0010);
        check("ch1_y", 16'(y), 16'b0011);
`ifdef EDGE_CNT_SAT_EN
        read(1, 4'd15, "ch1_cnt");
`else
        read(1, 4'd1, "ch1_cnt");
`endif

        // capture holds through further edges while rd_req stays high
        repeat (3) pulse(2);
        step(2);
        rd_bus.rd_sel = 2'd2;
        rd_bus.rd_req = 1'b1;
        step(1);
        check("ch2_ack", 16'(rd_bus.rd_ack), 16'd1);
        check("ch2_data", 16'(rd_bus.rd_data), 16'd3);
        repeat (2) pulse(2);
        step(2);
        check("ch2_hold_data", 16'(rd_bus.rd_data), 16'd3);
        check("ch2_hold_ack", 16'(rd_bus.rd_ack), 16'd1);
        rd_bus.rd_req = 1'b0;
        step(1);
        check("ch2_ack_drop", 16'(rd_bus.rd_ack), 16'd0);
        check("ch2_data_kept", 16'(rd_bus.rd_data), 16'd3);
        read(2, 4'd5, "ch2_cnt5");

        // channel 0 to 21 events, then clr coincident with a rise
        repeat (20) pulse(0);
        step(2);
        check("ch0_ovf", 16'(ovf), 16'b0011);
`ifdef EDGE_CNT_SAT_EN
        read(0, 4'd15, "ch0_cnt21");
`else
        read(0, 4'd5, "ch0_cnt21");
`endif
        a[0] = 1'b1;
        step(2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_x", 16'(x), 16'b0001);
        check("clr_ovf", 16'(ovf), 16'd0);
        check("clr_y", 16'(y), 16'b0110);
        read(0, 4'd0, "clr_ch0");
        read(1, 4'd0, "clr_ch1");
        a[0] = 1'b0;
        step(2);

        // build y=1010 with ovf[3] set, then reset mid-handshake
        pulse(2);
        repeat (17) pulse(3);
        step(2);
        rd_bus.rd_sel = 2'd3;
        rd_bus.rd_req = 1'b1;
        step(1);
        check("pre_rst_ack", 16'(rd_bus.rd_ack), 16'd1);
        check("pre_rst_y", 16'(y), 16'b1010);
        check("pre_rst_ovf", 16'(ovf), 16'b1000);
        reset_n = 1'b0;
        #1;
        check("async_ack", 16'(rd_bus.rd_ack), 16'd0);
        check("async_data", 16'(rd_bus.rd_data), 16'd0);
        check("async_y", 16'(y), 16'd0);
        check("async_x", 16'(x), 16'd0);
        check("async_ovf", 16'(ovf), 16'd0);
        rd_bus.rd_req = 1'b0;
        a[0] = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(2);
        check("rel_x_early", 16'(x), 16'd0);
        step(1);
        check("rel_x_pulse", 16'(x), 16'b0001);
        a[0] = 1'b0;
        step(3);

        done = 1'b1;
        step(1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
